// File: rtl/mips_multicycle_ctrl_v2.sv
// mips_multicycle_ctrl_v2
// Control FSM for a multicycle MIPS datapath with load/store, ADDI, a
// memory-ready handshake and an illegal-opcode flag.
//
// Ports:
//   CLK            rising-edge clock
//   Reset          asynchronous, active-high; forces Fetch and zeroes all outputs
//   Opcode         IR opcode field (read in Decode and Mem1)
//   MemReady       memory access completes this cycle
//   ALUOp, ALUSrcA, ALUSrcB, MemtoReg, RegDst, RegWrite, MemRead, MemWrite,
//   IorD, IRWrite, PCWrite, PCWriteCond, PCSource
//                  datapath controls, combinational from the state
//   IllegalOp      one-cycle flag for an unrecognised opcode or unused state
//   current_state  state register
//   next_state     combinational next state
module mips_multicycle_ctrl_v2 #(
    parameter int unsigned OPCODE_W      = 6,
    parameter int unsigned STATE_W       = 4,
    parameter int unsigned OP_RTYPE      = 0,
    parameter int unsigned OP_J          = 2,
    parameter int unsigned OP_BEQ        = 4,
    parameter int unsigned OP_ADDI       = 8,
    parameter int unsigned OP_LW         = 35,
    parameter int unsigned OP_SW         = 43,
    parameter int unsigned MEM_HANDSHAKE = 1
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                MemReady,
    output logic [1:0]          ALUOp,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IorD,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic [1:0]          PCSource,
    output logic                IllegalOp,
    output logic [STATE_W-1:0]  current_state,
    output logic [STATE_W-1:0]  next_state
);

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH      = STATE_W'(0),
        ST_DECODE     = STATE_W'(1),
        ST_MEM1       = STATE_W'(2),
        ST_LW1        = STATE_W'(3),
        ST_LW2        = STATE_W'(4),
        ST_SW1        = STATE_W'(5),
        ST_REXEC      = STATE_W'(6),
        ST_RWRITE     = STATE_W'(7),
        ST_BRANCH     = STATE_W'(8),
        ST_JUMP       = STATE_W'(9),
        ST_ADDI_EXEC  = STATE_W'(10),
        ST_ADDI_WRITE = STATE_W'(11)
    } state_e;

    localparam logic [OPCODE_W-1:0] OPC_RTYPE = OPCODE_W'(OP_RTYPE);
    localparam logic [OPCODE_W-1:0] OPC_J     = OPCODE_W'(OP_J);
    localparam logic [OPCODE_W-1:0] OPC_BEQ   = OPCODE_W'(OP_BEQ);
    localparam logic [OPCODE_W-1:0] OPC_ADDI  = OPCODE_W'(OP_ADDI);
    localparam logic [OPCODE_W-1:0] OPC_LW    = OPCODE_W'(OP_LW);
    localparam logic [OPCODE_W-1:0] OPC_SW    = OPCODE_W'(OP_SW);

    state_e state_q;
    state_e state_d;
    logic   mem_rdy;

    // With the handshake disabled memory is treated as single-cycle.
    assign mem_rdy = (MEM_HANDSHAKE != 0) ? MemReady : 1'b1;

    // State register.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode; Reset overrides combinationally so that
    // writes drop in the same cycle reset is asserted.
    always_comb begin
        state_d     = ST_FETCH;
        ALUOp       = 2'd0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'd0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 2'd0;
        IllegalOp   = 1'b0;

        case (state_q)
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'd1;
                if (mem_rdy) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                ALUSrcB = 2'd3;
                if (Opcode == OPC_RTYPE) begin
                    state_d = ST_REXEC;
                end else if (Opcode == OPC_J) begin
                    state_d = ST_JUMP;
                end else if (Opcode == OPC_BEQ) begin
                    state_d = ST_BRANCH;
                end else if (Opcode == OPC_ADDI) begin
                    state_d = ST_ADDI_EXEC;
                end else if ((Opcode == OPC_LW) || (Opcode == OPC_SW)) begin
                    state_d = ST_MEM1;
                end else begin
                    IllegalOp = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_MEM1: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                state_d = (Opcode == OPC_LW) ? ST_LW1 : ST_SW1;
            end
            ST_LW1: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = mem_rdy ? ST_LW2 : ST_LW1;
            end
            ST_LW2: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_SW1: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                state_d  = mem_rdy ? ST_FETCH : ST_SW1;
            end
            ST_REXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'd2;
                state_d = ST_RWRITE;
            end
            ST_RWRITE: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'd1;
                PCWriteCond = 1'b1;
                PCSource    = 2'd1;
                state_d     = ST_FETCH;
            end
            ST_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'd2;
                state_d  = ST_FETCH;
            end
            ST_ADDI_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                state_d = ST_ADDI_WRITE;
            end
            ST_ADDI_WRITE: begin
                RegWrite = 1'b1;
                state_d  = ST_FETCH;
            end
            default: begin
                // Unused encoding: flag it and recover through Fetch.
                IllegalOp = 1'b1;
                state_d   = ST_FETCH;
            end
        endcase

        if (Reset) begin
            state_d     = ST_FETCH;
            ALUOp       = 2'd0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'd0;
            MemtoReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IorD        = 1'b0;
            IRWrite     = 1'b0;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            PCSource    = 2'd0;
            IllegalOp   = 1'b0;
        end
    end

    assign current_state = state_q;
    assign next_state    = state_d;

endmodule

// File: tb/tb_mips_multicycle_ctrl_v2.sv
// Testbench for mips_multicycle_ctrl_v2: table-driven state/control vectors
// plus hand-written reset-mid-instruction sequences.
module tb_mips_multicycle_ctrl_v2;

    logic       CLK;
    logic       Reset;
    logic [5:0] Opcode;
    logic       MemReady;
    logic [1:0] ALUOp;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       MemtoReg, RegDst, RegWrite, MemRead, MemWrite;
    logic       IorD, IRWrite, PCWrite, PCWriteCond;
    logic [1:0] PCSource;
    logic       IllegalOp;
    logic [3:0] current_state;
    logic [3:0] next_state;

    mips_multicycle_ctrl_v2 dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .Opcode       (Opcode),
        .MemReady     (MemReady),
        .ALUOp        (ALUOp),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .MemtoReg     (MemtoReg),
        .RegDst       (RegDst),
        .RegWrite     (RegWrite),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .IorD         (IorD),
        .IRWrite      (IRWrite),
        .PCWrite      (PCWrite),
        .PCWriteCond  (PCWriteCond),
        .PCSource     (PCSource),
        .IllegalOp    (IllegalOp),
        .current_state(current_state),
        .next_state   (next_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Control bundle order:
    // {ALUOp,ALUSrcA,ALUSrcB,MemtoReg,RegDst,RegWrite,MemRead,MemWrite,
    //  IorD,IRWrite,PCWrite,PCWriteCond,PCSource,IllegalOp}
    logic [17:0] act_ctrl;
    assign act_ctrl = {ALUOp, ALUSrcA, ALUSrcB, MemtoReg, RegDst, RegWrite,
                       MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond,
                       PCSource, IllegalOp};

    function automatic logic [17:0] mk(
        input logic [1:0] aluop, input logic srca, input logic [1:0] srcb,
        input logic m2r, input logic rdst, input logic rw, input logic mrd,
        input logic mwr, input logic iord, input logic irw, input logic pcw,
        input logic pcwc, input logic [1:0] pcsrc, input logic ill);
        return {aluop, srca, srcb, m2r, rdst, rw, mrd, mwr, iord, irw, pcw,
                pcwc, pcsrc, ill};
    endfunction

    logic [17:0] C_NONE, C_FETCH_RDY, C_FETCH_WAIT, C_DECODE, C_DECODE_ILL;
    logic [17:0] C_MEM1, C_LW1, C_LW2, C_SW1, C_REXEC, C_RWRITE;
    logic [17:0] C_BRANCH, C_JUMP, C_ADDI_EXEC, C_ADDI_WRITE;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  exp_state;
        logic [3:0]  exp_next;
        logic [17:0] exp_ctrl;
    } vec_t;

    vec_t vecs[$];
    int   total;
    int   bad;

    task automatic add(input logic rst, input logic [5:0] op, input logic mr,
                       input logic [3:0] st, input logic [3:0] nx,
                       input logic [17:0] ctrl);
        vec_t v;
        v.rst = rst; v.op = op; v.mr = mr;
        v.exp_state = st; v.exp_next = nx; v.exp_ctrl = ctrl;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Drive inputs, settle, check combinational outputs of the present state.
    task automatic apply_check(input string tag, input int idx,
                               input logic rst, input logic [5:0] op,
                               input logic mr, input logic [3:0] st,
                               input logic [3:0] nx, input logic [17:0] ctrl);
        Reset = rst; Opcode = op; MemReady = mr;
        #1;
        chk({tag, ".state"}, idx, 32'(current_state), 32'(st));
        chk({tag, ".next"},  idx, 32'(next_state),    32'(nx));
        chk({tag, ".ctrl"},  idx, 32'(act_ctrl),      32'(ctrl));
    endtask

    initial begin
        total = 0;
        bad   = 0;

        C_NONE       = '0;
        C_FETCH_RDY  = mk(2'd0,0,2'd1, 0,0,0, 1,0,0, 1,1,0, 2'd0, 0);
        C_FETCH_WAIT = mk(2'd0,0,2'd1, 0,0,0, 1,0,0, 0,0,0, 2'd0, 0);
        C_DECODE     = mk(2'd0,0,2'd3, 0,0,0, 0,0,0, 0,0,0, 2'd0, 0);
        C_DECODE_ILL = mk(2'd0,0,2'd3, 0,0,0, 0,0,0, 0,0,0, 2'd0, 1);
        C_MEM1       = mk(2'd0,1,2'd2, 0,0,0, 0,0,0, 0,0,0, 2'd0, 0);
        C_LW1        = mk(2'd0,0,2'd0, 0,0,0, 1,0,1, 0,0,0, 2'd0, 0);
        C_LW2        = mk(2'd0,0,2'd0, 1,0,1, 0,0,0, 0,0,0, 2'd0, 0);
        C_SW1        = mk(2'd0,0,2'd0, 0,0,0, 0,1,1, 0,0,0, 2'd0, 0);
        C_REXEC      = mk(2'd2,1,2'd0, 0,0,0, 0,0,0, 0,0,0, 2'd0, 0);
        C_RWRITE     = mk(2'd0,0,2'd0, 0,1,1, 0,0,0, 0,0,0, 2'd0, 0);
        C_BRANCH     = mk(2'd1,1,2'd0, 0,0,0, 0,0,0, 0,0,1, 2'd1, 0);
        C_JUMP       = mk(2'd0,0,2'd0, 0,0,0, 0,0,0, 0,1,0, 2'd2, 0);
        C_ADDI_EXEC  = mk(2'd0,1,2'd2, 0,0,0, 0,0,0, 0,0,0, 2'd0, 0);
        C_ADDI_WRITE = mk(2'd0,0,2'd0, 0,0,1, 0,0,0, 0,0,0, 2'd0, 0);

        // reset held
        add(1, 6'd0,  1, 4'd0,  4'd0,  C_NONE);
        add(1, 6'd35, 0, 4'd0,  4'd0,  C_NONE);
        // R-type
        add(0, 6'd0,  1, 4'd0,  4'd1,  C_FETCH_RDY);
        add(0, 6'd0,  1, 4'd1,  4'd6,  C_DECODE);
        add(0, 6'd0,  1, 4'd6,  4'd7,  C_REXEC);
        add(0, 6'd0,  1, 4'd7,  4'd0,  C_RWRITE);
        // LW with three wait cycles in LW1
        add(0, 6'd35, 1, 4'd0,  4'd1,  C_FETCH_RDY);
        add(0, 6'd35, 1, 4'd1,  4'd2,  C_DECODE);
        add(0, 6'd35, 1, 4'd2,  4'd3,  C_MEM1);
        add(0, 6'd35, 0, 4'd3,  4'd3,  C_LW1);
        add(0, 6'd35, 0, 4'd3,  4'd3,  C_LW1);
        add(0, 6'd35, 0, 4'd3,  4'd3,  C_LW1);
        add(0, 6'd35, 1, 4'd3,  4'd4,  C_LW1);
        add(0, 6'd35, 1, 4'd4,  4'd0,  C_LW2);
        // Fetch stalled on memory
        add(0, 6'd43, 0, 4'd0,  4'd0,  C_FETCH_WAIT);
        add(0, 6'd43, 0, 4'd0,  4'd0,  C_FETCH_WAIT);
        // SW with two wait cycles in SW1
        add(0, 6'd43, 1, 4'd0,  4'd1,  C_FETCH_RDY);
        add(0, 6'd43, 1, 4'd1,  4'd2,  C_DECODE);
        add(0, 6'd43, 1, 4'd2,  4'd5,  C_MEM1);
        add(0, 6'd43, 0, 4'd5,  4'd5,  C_SW1);
        add(0, 6'd43, 0, 4'd5,  4'd5,  C_SW1);
        add(0, 6'd43, 1, 4'd5,  4'd0,  C_SW1);
        // BEQ
        add(0, 6'd4,  1, 4'd0,  4'd1,  C_FETCH_RDY);
        add(0, 6'd4,  1, 4'd1,  4'd8,  C_DECODE);
        add(0, 6'd4,  1, 4'd8,  4'd0,  C_BRANCH);
        // J
        add(0, 6'd2,  1, 4'd0,  4'd1,  C_FETCH_RDY);
        add(0, 6'd2,  1, 4'd1,  4'd9,  C_DECODE);
        add(0, 6'd2,  1, 4'd9,  4'd0,  C_JUMP);
        // ADDI
        add(0, 6'd8,  1, 4'd0,  4'd1,  C_FETCH_RDY);
        add(0, 6'd8,  1, 4'd1,  4'd10, C_DECODE);
        add(0, 6'd8,  1, 4'd10, 4'd11, C_ADDI_EXEC);
        add(0, 6'd8,  1, 4'd11, 4'd0,  C_ADDI_WRITE);
        // Illegal opcode: flag for exactly one cycle
        add(0, 6'd63, 1, 4'd0,  4'd1,  C_FETCH_RDY);
        add(0, 6'd63, 1, 4'd1,  4'd0,  C_DECODE_ILL);
        add(0, 6'd63, 0, 4'd0,  4'd0,  C_FETCH_WAIT);
        // Neighbouring unused opcode also illegal
        add(0, 6'd9,  1, 4'd0,  4'd1,  C_FETCH_RDY);
        add(0, 6'd9,  1, 4'd1,  4'd0,  C_DECODE_ILL);
        add(0, 6'd9,  0, 4'd0,  4'd0,  C_FETCH_WAIT);

        Reset = 1'b1; Opcode = '0; MemReady = 1'b0;
        step();

        foreach (vecs[i]) begin
            apply_check("vec", i, vecs[i].rst, vecs[i].op, vecs[i].mr,
                        vecs[i].exp_state, vecs[i].exp_next, vecs[i].exp_ctrl);
            step();
        end

        // Reset during SW1 drops MemWrite without a clock edge.
        apply_check("sw_rst", 0, 0, 6'd43, 1, 4'd0, 4'd1, C_FETCH_RDY); step();
        apply_check("sw_rst", 1, 0, 6'd43, 1, 4'd1, 4'd2, C_DECODE);    step();
        apply_check("sw_rst", 2, 0, 6'd43, 1, 4'd2, 4'd5, C_MEM1);      step();
        apply_check("sw_rst", 3, 0, 6'd43, 0, 4'd5, 4'd5, C_SW1);
        apply_check("sw_rst", 4, 1, 6'd43, 0, 4'd0, 4'd0, C_NONE);
        chk("sw_rst.memwrite", 5, 32'(MemWrite), 32'd0);
        step();
        apply_check("sw_rst", 6, 1, 6'd43, 1, 4'd0, 4'd0, C_NONE);      step();
        apply_check("sw_rst", 7, 0, 6'd43, 1, 4'd0, 4'd1, C_FETCH_RDY); step();

        // Reset during RWrite drops RegWrite immediately.
        apply_check("rw_rst", 0, 0, 6'd0, 1, 4'd1, 4'd6, C_DECODE);     step();
        apply_check("rw_rst", 1, 0, 6'd0, 1, 4'd6, 4'd7, C_REXEC);      step();
        apply_check("rw_rst", 2, 0, 6'd0, 1, 4'd7, 4'd0, C_RWRITE);
        apply_check("rw_rst", 3, 1, 6'd0, 1, 4'd0, 4'd0, C_NONE);
        step();
        apply_check("rw_rst", 4, 0, 6'd0, 1, 4'd0, 4'd1, C_FETCH_RDY);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
